// File: rtl/usb_link_seq.sv
// rtl/usb_link_seq.sv - ULPI PHY attach/detach sequencer; FUNCT_CTL readback verify under USB_LINK_SEQ_VERIFY_EN
module usb_link_seq #(
    parameter int           DEBOUNCE_CYCLES = 1000,
    parameter int           TIMEOUT_CYCLES  = 255,
    parameter int           MAX_RETRY       = 3,
    parameter logic [7:0]   OTG_CTL_VAL     = 8'h00,
    parameter logic [7:0]   FUNCT_CONN_FS   = 8'h45,
    parameter logic [7:0]   FUNCT_CONN_HS   = 8'h44,
    parameter logic [7:0]   FUNCT_DISC      = 8'h49
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       usb_enable,
    input  logic       hs_enable,
    input  logic [1:0] vbus_state,
    output logic       reg_en,
    input  logic       reg_rdy,
    output logic       reg_we,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_din,
    input  logic [7:0] reg_dout,
    output logic       connected,
    output logic       busy,
    output logic       speed_hs,
    output logic       error
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE_CYCLES);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);
    localparam logic [7:0]    ADDR_OTG   = 8'h0A;
    localparam logic [7:0]    ADDR_FUNCT = 8'h04;

    typedef enum logic [2:0] {
        S_DISC, S_WR_OTG, S_WR_FUNCT, S_RD_FUNCT, S_CONN, S_ERR
    } main_e;

    typedef enum logic [1:0] {
        A_IDLE, A_ISSUE, A_WAIT, A_DONE
    } acc_e;

    function automatic logic is_access(input main_e s);
        return (s == S_WR_OTG) || (s == S_WR_FUNCT) || (s == S_RD_FUNCT);
    endfunction

    // Reset asserts asynchronously but releases only after two clean clock edges.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= rst_sync_d;
    end
    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rst_int_n  = rst_sync_q[1];

    main_e          state_q, state_d;
    acc_e           acc_q, acc_d;
    logic [DW-1:0]  db_cnt_q, db_cnt_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic [3:0]     retry_q, retry_d;
    logic           mode_conn_q, mode_conn_d;
    logic           speed_hs_q, speed_hs_d;
    logic           match_q, match_d;
    logic           reg_en_q, reg_en_d;
    logic           reg_we_q, reg_we_d;
    logic           busy_q, busy_d;
    logic           connected_q, connected_d;
    logic           error_q, error_d;

    logic       vbus_ok, target, done, timeout;
    main_e      seq_end;
    logic [7:0] funct_val;

    assign vbus_ok   = (db_cnt_q == DB_MAX);
    assign target    = usb_enable & vbus_ok;
    assign funct_val = mode_conn_q ? (speed_hs_q ? FUNCT_CONN_HS : FUNCT_CONN_FS) : FUNCT_DISC;
    assign seq_end   = mode_conn_q ? S_CONN : S_DISC;
    assign done      = (acc_q == A_DONE);

    always_comb begin
        db_cnt_d    = db_cnt_q;
        state_d     = state_q;
        acc_d       = acc_q;
        tmo_d       = tmo_q;
        retry_d     = retry_q;
        mode_conn_d = mode_conn_q;
        speed_hs_d  = speed_hs_q;
        match_d     = match_q;
        timeout     = 1'b0;

        if (vbus_state == 2'b11) begin
            if (!vbus_ok) db_cnt_d = db_cnt_q + 1'b1;
        end else begin
            db_cnt_d = '0;
        end

        unique case (acc_q)
            A_IDLE:  if (is_access(state_q)) acc_d = A_ISSUE;
            A_ISSUE: begin
                acc_d = A_WAIT;
                tmo_d = '0;
            end
            A_WAIT: begin
                if (reg_rdy) begin
                    acc_d   = A_DONE;
                    match_d = (reg_dout == funct_val);
                end else if (tmo_q == TMO_LAST) begin
                    acc_d   = A_IDLE;
                    timeout = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            A_DONE:  acc_d = A_IDLE;
            default: acc_d = A_IDLE;
        endcase

        unique case (state_q)
            S_DISC: if (target) begin
                state_d     = S_WR_OTG;
                mode_conn_d = 1'b1;
                speed_hs_d  = hs_enable;
                retry_d     = '0;
            end
            S_CONN: if (!target || (hs_enable != speed_hs_q)) begin
                state_d     = S_WR_OTG;
                mode_conn_d = 1'b0;
                retry_d     = '0;
            end
            S_WR_OTG: if (done) state_d = S_WR_FUNCT;
            S_WR_FUNCT: if (done) begin
`ifdef USB_LINK_SEQ_VERIFY_EN
                state_d = S_RD_FUNCT;
`else
                state_d = seq_end;
`endif
            end
            S_RD_FUNCT: if (done) begin
                if (match_q)                   state_d = seq_end;
                else if (retry_q == RETRY_MAX) state_d = S_ERR;
                else begin
                    retry_d = retry_q + 1'b1;
                    state_d = S_WR_FUNCT;
                end
            end
            S_ERR:   if (!usb_enable) state_d = S_DISC;
            default: state_d = S_DISC;
        endcase

        // A timed-out access stays in its state; the sub-FSM reissues it from IDLE.
        if (timeout) begin
            if (retry_q == RETRY_MAX) state_d = S_ERR;
            else                      retry_d = retry_q + 1'b1;
        end
    end

    assign reg_en_d    = (acc_d == A_ISSUE);
    assign reg_we_d    = (acc_d == A_ISSUE) && (state_d != S_RD_FUNCT);
    assign busy_d      = is_access(state_d);
    assign connected_d = (state_d == S_CONN);
    assign error_d     = (state_d == S_ERR);

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q     <= S_DISC;
            acc_q       <= A_IDLE;
            db_cnt_q    <= '0;
            tmo_q       <= '0;
            retry_q     <= '0;
            mode_conn_q <= 1'b0;
            speed_hs_q  <= 1'b0;
            match_q     <= 1'b0;
            reg_en_q    <= 1'b0;
            reg_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            connected_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            db_cnt_q    <= db_cnt_d;
            tmo_q       <= tmo_d;
            retry_q     <= retry_d;
            mode_conn_q <= mode_conn_d;
            speed_hs_q  <= speed_hs_d;
            match_q     <= match_d;
            reg_en_q    <= reg_en_d;
            reg_we_q    <= reg_we_d;
            busy_q      <= busy_d;
            connected_q <= connected_d;
            error_q     <= error_d;
        end
    end

    always_comb begin
        reg_addr = 8'h00;
        reg_din  = 8'h00;
        unique case (state_q)
            S_WR_OTG: begin
                reg_addr = ADDR_OTG;
                reg_din  = OTG_CTL_VAL;
            end
            S_WR_FUNCT, S_RD_FUNCT: begin
                reg_addr = ADDR_FUNCT;
                reg_din  = funct_val;
            end
            default: ;
        endcase
    end

    assign reg_en    = reg_en_q;
    assign reg_we    = reg_we_q;
    assign busy      = busy_q;
    assign connected = connected_q;
    assign error     = error_q;
    assign speed_hs  = speed_hs_q;

endmodule

// File: tb/tb_usb_link_seq.sv
// tb/tb_usb_link_seq.sv - bench for usb_link_seq with an access-sequence model
module tb_usb_link_seq;

`ifdef USB_LINK_SEQ_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif
    localparam int SEQ_N = VERIFY ? 3 : 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       usb_enable = 1'b0;
    logic       hs_enable = 1'b0;
    logic [1:0] vbus_state = 2'b00;
    logic       reg_en;
    logic       reg_rdy = 1'b0;
    logic       reg_we;
    logic [7:0] reg_addr;
    logic [7:0] reg_din;
    logic [7:0] reg_dout = 8'h00;
    logic       connected;
    logic       busy;
    logic       speed_hs;
    logic       error;

    usb_link_seq #(
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (8),
        .MAX_RETRY      (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .usb_enable(usb_enable),
        .hs_enable (hs_enable),
        .vbus_state(vbus_state),
        .reg_en    (reg_en),
        .reg_rdy   (reg_rdy),
        .reg_we    (reg_we),
        .reg_addr  (reg_addr),
        .reg_din   (reg_din),
        .reg_dout  (reg_dout),
        .connected (connected),
        .busy      (busy),
        .speed_hs  (speed_hs),
        .error     (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] din;
    } acc_t;

    acc_t       exp_q[$];
    acc_t       obs_q[$];
    logic [7:0] rd_q[$];
    int         en_cyc[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         rdy_delay = 2;
    int         pend = 0;
    logic       pend_rd = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected register traffic for one sequence, built from the FUNCT_CTL rules.
    task automatic push_seq(input bit conn, input bit hs, input int n_mis);
        logic [7:0] f;
        f = conn ? (hs ? 8'h44 : 8'h45) : 8'h49;
        exp_q.push_back('{1'b1, 8'h0A, 8'h00});
        exp_q.push_back('{1'b1, 8'h04, f});
        if (VERIFY) begin
            for (int i = 0; i < n_mis; i++) begin
                exp_q.push_back('{1'b0, 8'h04, f});
                rd_q.push_back(8'h00);
                exp_q.push_back('{1'b1, 8'h04, f});
            end
            exp_q.push_back('{1'b0, 8'h04, f});
            rd_q.push_back(f);
        end
    endtask

    // PHY-side responder: reg_rdy rdy_delay negedges after reg_en, never when 0.
    always @(negedge clk) begin
        reg_rdy = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                reg_rdy  = 1'b1;
                reg_dout = (pend_rd && rd_q.size() > 0) ? rd_q.pop_front() : 8'h00;
            end
        end
        if (reg_en && rdy_delay > 0) begin
            pend    = rdy_delay;
            pend_rd = !reg_we;
        end
    end

    always @(negedge clk) begin
        acc_t a;
        acc_t e;
        cyc++;
        chk("inv_busy_and_conn", 32'(busy & connected), 32'd0);
        chk("inv_err_exclusive", 32'(error & (busy | connected)), 32'd0);
        if (!busy) begin
            chk("idle_reg_addr", 32'(reg_addr), 32'd0);
            chk("idle_reg_din", 32'(reg_din), 32'd0);
        end
        if (reg_en) begin
            a = '{reg_we, reg_addr, reg_din};
            obs_q.push_back(a);
            en_cyc.push_back(cyc);
            chk("reg_en_while_busy", 32'(busy), 32'd1);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_access: got we=%0b addr=%0h din=%0h required none", a.we, a.addr, a.din);
            end else begin
                e = exp_q.pop_front();
                chk("acc_we", 32'(a.we), 32'(e.we));
                chk("acc_addr", 32'(a.addr), 32'(e.addr));
                chk("acc_din", 32'(a.din), 32'(e.din));
            end
        end
    end

    task automatic wait_busy(input string nm);
        int n = 0;
        while (!busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(busy), 32'd1);
    endtask

    task automatic wait_conn(input string nm, input logic want);
        int n = 0;
        while (!(connected == want && !busy && !error) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(connected), 32'(want));
    endtask

    initial begin
        int n;
        int base;
        rst_n = 1'b0;
        #2;
        chk("rst_outputs", 32'({reg_en, reg_we, reg_addr, reg_din, connected, busy, speed_hs, error}), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Short VBUS pulse must not attach.
        usb_enable = 1'b1;
        vbus_state = 2'b11;
        repeat (3) @(negedge clk);
        vbus_state = 2'b01;
        repeat (4) @(negedge clk);
        chk("debounce_no_busy", 32'(busy), 32'd0);
        chk("debounce_no_access", 32'(obs_q.size()), 32'd0);

        // Attach FS: busy appears the cycle after the 4th valid sample.
        push_seq(1'b0 | 1'b1, 1'b0, 0);
        vbus_state = 2'b11;
        n = 0;
        while (!busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("debounce_latency", 32'(n), 32'd5);
        wait_conn("attach_connected", 1'b1);
        chk("attach_speed_fs", 32'(speed_hs), 32'd0);
        chk("attach_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("attach_n_acc", 32'(obs_q.size()), 32'(SEQ_N));
        chk("attach_acc0_addr", 32'(obs_q[0].addr), 32'h0A);
        chk("attach_acc1_din", 32'(obs_q[1].din), 32'h45);

        // Speed change to HS: disconnect (49) then reconnect (44).
        base = obs_q.size();
        push_seq(1'b0, 1'b0, 0);
        push_seq(1'b1, 1'b1, 0);
        hs_enable = 1'b1;
        wait_busy("hs_change_start");
        wait_conn("hs_connected", 1'b1);
        chk("hs_speed", 32'(speed_hs), 32'd1);
        chk("hs_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("hs_disc_din", 32'(obs_q[base + 1].din), 32'h49);
        chk("hs_conn_din", 32'(obs_q[base + SEQ_N + 1].din), 32'h44);

        // Back to FS.
        push_seq(1'b0, 1'b0, 0);
        push_seq(1'b1, 1'b0, 0);
        hs_enable = 1'b0;
        wait_busy("fs_change_start");
        wait_conn("fs_connected", 1'b1);
        chk("fs_speed", 32'(speed_hs), 32'd0);
        chk("fs_queue_empty", 32'(exp_q.size()), 32'd0);

        // Detach, then reattach with one bad readback.
        push_seq(1'b0, 1'b0, 0);
        usb_enable = 1'b0;
        wait_busy("detach_start");
        wait_conn("detached", 1'b0);
        base = obs_q.size();
        push_seq(1'b1, 1'b0, 1);
        usb_enable = 1'b1;
        wait_busy("mismatch_start");
        wait_conn("mismatch_connected", 1'b1);
        chk("mismatch_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("mismatch_n_acc", 32'(obs_q.size() - base), VERIFY ? 32'd5 : 32'd2);

        // Detach normally, then attach against a silent PHY.
        push_seq(1'b0, 1'b0, 0);
        usb_enable = 1'b0;
        wait_busy("detach2_start");
        wait_conn("detached2", 1'b0);
        rdy_delay = 0;
        base = en_cyc.size();
        for (int i = 0; i < 3; i++) exp_q.push_back('{1'b1, 8'h0A, 8'h00});
        usb_enable = 1'b1;
        n = 0;
        while (!error && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_error", 32'(error), 32'd1);
        chk("timeout_busy", 32'(busy), 32'd0);
        chk("timeout_pulses", 32'(en_cyc.size() - base), 32'd3);
        if (en_cyc.size() - base == 3) begin
            chk("timeout_gap0", 32'(en_cyc[base + 1] - en_cyc[base]), 32'd10);
            chk("timeout_gap1", 32'(en_cyc[base + 2] - en_cyc[base + 1]), 32'd10);
        end
        repeat (3) @(negedge clk);
        chk("error_sticky", 32'(error), 32'd1);
        usb_enable = 1'b0;
        @(negedge clk);
        chk("error_cleared", 32'(error), 32'd0);
        chk("error_to_disc", 32'(connected | busy), 32'd0);

        // Async reset in the middle of a register wait.
        exp_q.push_back('{1'b1, 8'h0A, 8'h00});
        usb_enable = 1'b1;
        n = 0;
        while (!reg_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("arst_saw_reg_en", 32'(reg_en), 32'd1);
        @(negedge clk);
        chk("arst_busy_before", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_outputs", 32'({reg_en, reg_we, reg_addr, reg_din, connected, busy, speed_hs, error}), 32'd0);
        exp_q.delete();
        rd_q.delete();
        usb_enable = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("arst_stays_idle", 32'({connected, busy, error}), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/usb_link_seq.md
Name: usb_link_seq

Overview:
- Parametrised successor to the ULPI connect/disconnect sequencer; owns the PHY attach state for the USB device core.
- Adds debounced VBUS, FS/HS speed selection, register-access timeout with bounded retry, optional FUNCT_CTL readback verify, and status outputs.
- Sits between the top-level enable/VBUS logic and the ULPI register port arbiter.

Parameters:
- DEBOUNCE_CYCLES, 1000, consecutive cycles vbus_state==2'b11 required before VBUS is valid (>=1)
- TIMEOUT_CYCLES, 255, max cycles waiting for reg_rdy per access (>=1)
- MAX_RETRY, 3, retries allowed per sequence before error (0..15)
- OTG_CTL_VAL, 8'h00, value written to OTG_CTL (8'h0A)
- FUNCT_CONN_FS, 8'h45, FUNCT_CTL (8'h04) value for FS connect
- FUNCT_CONN_HS, 8'h44, FUNCT_CTL value for HS connect
- FUNCT_DISC, 8'h49, FUNCT_CTL value for disconnect (non-driving)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- usb_enable  in  1  software attach request
- hs_enable  in  1  1=HS, 0=FS; sampled at sequence start
- vbus_state  in  2  PHY VBUS comparator state; 2'b11 = valid
- reg_en  out  1  register access strobe, one cycle per access
- reg_rdy  in  1  access complete
- reg_we  out  1  1=write, 0=read; valid with reg_en
- reg_addr  out  8  register address
- reg_din  out  8  write data
- reg_dout  in  8  read data, valid when reg_rdy=1
- connected  out  1  link attached (state CONNECTED)
- busy  out  1  sequence in progress
- speed_hs  out  1  latched speed of current/last connect
- error  out  1  sticky sequence failure

Behaviour:
- Reset (async assert, sync deassert via flops on clk): all state to DISCONNECTED / IDLE, counters 0. All outputs 0.
- VBUS debounce:
  - Counter increments while vbus_state==2'b11, saturating at DEBOUNCE_CYCLES; vbus_ok=1 when count==DEBOUNCE_CYCLES.
  - Any other vbus_state value clears the count and vbus_ok on the next edge (loss is not debounced).
  - target = usb_enable & vbus_ok.
- Main FSM states: DISCONNECTED, WR_OTG, WR_FUNCT, RD_FUNCT, CONNECTED, ERROR.
  - DISCONNECTED -> WR_OTG when target. Latch mode_conn=1 and speed_hs=hs_enable; clear retry count.
  - CONNECTED -> WR_OTG when ~target or hs_enable!=speed_hs. Latch mode_conn=0; clear retry count.
  - WR_OTG -> WR_FUNCT on access done.
  - WR_FUNCT -> RD_FUNCT on done (verify enabled). Otherwise -> CONNECTED if mode_conn, else DISCONNECTED.
  - RD_FUNCT on done: if match, same exit as WR_FUNCT. If mismatch, retry++ and return to WR_FUNCT.
  - Timeout in any access state: retry++ and the same access reissues.
  - If retry would exceed MAX_RETRY: go to ERROR, error=1.
  - ERROR -> DISCONNECTED when usb_enable==0; error clears in the same cycle.
  - A disconnect sequence ending in DISCONNECTED with target still 1 starts a new connect on the next cycle. This is how a speed change works.
- FUNCT value:
  - mode_conn=1: speed_hs ? FUNCT_CONN_HS : FUNCT_CONN_FS.
  - mode_conn=0: FUNCT_DISC.
- Access sub-FSM: IDLE -> ISSUE (reg_en=1 exactly one cycle) -> WAIT -> DONE (one cycle) -> IDLE.
  - Leaves WAIT on reg_rdy, or after TIMEOUT_CYCLES without reg_rdy (timeout path skips DONE and returns to IDLE).
  - reg_rdy in the ISSUE cycle is ignored.
  - reg_we=1 in ISSUE for WR_OTG/WR_FUNCT; 0 for RD_FUNCT.
  - RD_FUNCT compares reg_dout in the cycle reg_rdy=1.
- reg_addr/reg_din are combinational from the main state; 8'h00 outside access states.
  - WR_OTG: addr 8'h0A, data OTG_CTL_VAL.
  - WR_FUNCT/RD_FUNCT: addr 8'h04, data = FUNCT value.
- Mid-sequence changes of usb_enable, hs_enable or VBUS are ignored until the sequence ends in CONNECTED or DISCONNECTED.
- Status outputs:
  - busy = main state in {WR_OTG, WR_FUNCT, RD_FUNCT}.
  - connected = (state==CONNECTED).

Optional Feature:
- Macro USB_LINK_SEQ_VERIFY_EN.
- Defined: RD_FUNCT readback and compare are active as above.
- Undefined: RD_FUNCT is never entered; WR_FUNCT exits directly; reg_dout is unused. Retries then come only from timeouts.

Test Plan:
- Attach: usb_enable=1, vbus=11 held, DEBOUNCE_CYCLES=4, reg_rdy 2 cycles after reg_en -> writes (0A,00), (04,45), then read 04. Return 45 -> connected=1, speed_hs=0.
- Debounce: vbus=11 for 3 cycles then 01 -> no reg_en. Then 11 for 4 cycles -> sequence starts the cycle after vbus_ok.
- HS and speed change: connect with hs_enable=1 (write 44), then hs_enable=0 -> writes 49, back to DISCONNECTED, then reconnect writing 45, speed_hs=0.
- Timeout: reg_rdy never asserted, TIMEOUT_CYCLES=8, MAX_RETRY=2 -> 3 reg_en pulses 10 cycles apart, then error=1, busy=0. Drop usb_enable -> error=0.
- Verify mismatch (macro on): readback 00, then 45 -> WR_FUNCT reissued once, connected=1. Macro off -> no read access at all.
- Async reset: assert rst_n=0 mid-WAIT -> all outputs 0 immediately, without waiting for a clock edge.
